gate_quiz_sequencer: RTL and testbench

Stimulus-and-scoring stage that sits directly upstream of the digital-gates stage in the trainer design. It debounces a step button and drives the 2-bit `a`/`b` operand pattern into the gate stage. It debounces a check button, reads back the gate stage's 8-bit result, and compares the selected gate bit against the user's guess. It keeps saturating attempt and correct counters for display.

---
 rtl/gate_quiz_sequencer.sv | 172 +++++++++++++++++
 tb/tb_gate_quiz_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_quiz_sequencer.sv
// Quiz sequencer for the gates trainer: debounced step/check buttons, operand pattern, scoring.
// Optional auto-step timer is compiled in with `define GATE_QUIZ_AUTO_EN.
module gate_quiz_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_DIV        = 1024,
    parameter int unsigned SCORE_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               step_btn,
    input  logic               check_btn,
    input  logic               auto_en,
    input  logic [2:0]         gate_sel,
    input  logic               guess,
    input  logic [7:0]         gate_res,
    output logic               a_out,
    output logic               b_out,
    output logic [SCORE_W-1:0] attempts,
    output logic [SCORE_W-1:0] correct,
    output logic               last_ok,
    output logic               last_bad,
    output logic               ready
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {StReady, StSettle, StJudge} state_e;

    // Index 0 is the step button, index 1 the check button.
    logic [1:0]           raw;
    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           db_q;
    logic [1:0]           db_prev_q;
    logic [1:0][CntW-1:0] cnt_q;
    logic [1:0]           btn_evt;

    state_e               state_q;
    logic                 settle_q;
    logic [1:0]           pat_q;
    logic [SCORE_W-1:0]   attempts_q;
    logic [SCORE_W-1:0]   correct_q;
    logic                 last_ok_q;
    logic                 last_bad_q;
    logic                 ready_q;

    logic                 auto_evt;
    logic                 step_evt;
    logic                 check_evt;
    logic                 match;

    assign raw = {check_btn, step_btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else if (ena) begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn_evt = db_q & ~db_prev_q;

`ifdef GATE_QUIZ_AUTO_EN
    localparam int unsigned TmrW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [TmrW-1:0] timer_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (ena) begin
            if (!auto_en || (timer_q == TmrW'(AUTO_DIV - 1))) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign auto_evt = auto_en && (timer_q == TmrW'(AUTO_DIV - 1));
`else
    logic unused_auto;

    assign unused_auto = auto_en | (AUTO_DIV == 0);
    assign auto_evt    = 1'b0;
`endif

    assign step_evt  = btn_evt[0] | auto_evt;
    assign check_evt = btn_evt[1];
    assign match     = (gate_res[gate_sel] == guess);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReady;
            settle_q   <= 1'b0;
            pat_q      <= 2'b00;
            attempts_q <= '0;
            correct_q  <= '0;
            last_ok_q  <= 1'b0;
            last_bad_q <= 1'b0;
            ready_q    <= 1'b1;
        end else if (ena) begin
            unique case (state_q)
                StReady: begin
                    // Step has priority; a simultaneous check is dropped.
                    if (step_evt) begin
                        pat_q      <= pat_q + 2'b01;
                        last_ok_q  <= 1'b0;
                        last_bad_q <= 1'b0;
                        settle_q   <= 1'b0;
                        state_q    <= StSettle;
                        ready_q    <= 1'b0;
                    end else if (check_evt) begin
                        state_q <= StJudge;
                        ready_q <= 1'b0;
                    end
                end
                StSettle: begin
                    if (settle_q) begin
                        state_q <= StReady;
                        ready_q <= 1'b1;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                StJudge: begin
                    if (attempts_q != '1) begin
                        attempts_q <= attempts_q + 1'b1;
                    end
                    if (match && (correct_q != '1)) begin
                        correct_q <= correct_q + 1'b1;
                    end
                    last_ok_q  <= match;
                    last_bad_q <= ~match;
                    state_q    <= StReady;
                    ready_q    <= 1'b1;
                end
                default: begin
                    state_q <= StReady;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign a_out    = pat_q[0];
    assign b_out    = pat_q[1];
    assign attempts = attempts_q;
    assign correct  = correct_q;
    assign last_ok  = last_ok_q;
    assign last_bad = last_bad_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_gate_quiz_sequencer.sv
// Directed bench for gate_quiz_sequencer with a behavioural gate stage downstream.
module tb_gate_quiz_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       step_btn;
    logic       check_btn;
    logic       auto_en;
    logic [2:0] gate_sel;
    logic       guess;
    logic [7:0] gate_res;
    logic       a_out;
    logic       b_out;
    logic [3:0] attempts;
    logic [3:0] correct;
    logic       last_ok;
    logic       last_bad;
    logic       ready;

    int checks = 0;
    int errors = 0;

    gate_quiz_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_DIV       (8),
        .SCORE_W        (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .step_btn (step_btn),
        .check_btn(check_btn),
        .auto_en  (auto_en),
        .gate_sel (gate_sel),
        .guess    (guess),
        .gate_res (gate_res),
        .a_out    (a_out),
        .b_out    (b_out),
        .attempts (attempts),
        .correct  (correct),
        .last_ok  (last_ok),
        .last_bad (last_bad),
        .ready    (ready)
    );

    // Gate stage: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 NOT b.
    assign gate_res = {~b_out, ~a_out, ~(a_out ^ b_out), ~(a_out | b_out),
                       ~(a_out & b_out), a_out ^ b_out, a_out | b_out, a_out & b_out};

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_step();
        step_btn = 1'b1;
        cyc(10);
        step_btn = 1'b0;
        cyc(8);
    endtask

    task automatic do_check();
        check_btn = 1'b1;
        cyc(10);
        check_btn = 1'b0;
        cyc(8);
    endtask

    function automatic logic [31:0] pat();
        return 32'({b_out, a_out});
    endfunction

    initial begin
        logic [1:0] p_exp;
        rst_n     = 1'b0;
        ena       = 1'b1;
        step_btn  = 1'b0;
        check_btn = 1'b0;
        auto_en   = 1'b0;
        gate_sel  = 3'd0;
        guess     = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_pat", pat(), 32'd0);
        chk("rst_cnt", 32'({attempts, correct}), 32'd0);
        chk("rst_flags", 32'({last_ok, last_bad}), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);

        // Short glitch must be filtered.
        step_btn = 1'b1;
        cyc(3);
        step_btn = 1'b0;
        cyc(12);
        chk("glitch_pat", pat(), 32'd0);

        // Clean press: pattern changes 7 cycles after the press, SETTLE for 2 cycles.
        step_btn = 1'b1;
        cyc(6);
        chk("press_before", pat(), 32'd0);
        chk("press_ready_e", 32'(ready), 32'd1);
        cyc(1);
        chk("press_after", pat(), 32'd1);
        chk("settle1", 32'(ready), 32'd0);
        cyc(1);
        chk("settle2", 32'(ready), 32'd0);
        cyc(1);
        chk("settle_done", 32'(ready), 32'd1);
        cyc(1);
        step_btn = 1'b0;
        cyc(8);
        chk("press_once", pat(), 32'd1);
        do_step();
        chk("pat_10", pat(), 32'd2);
        do_step();
        chk("pat_11", pat(), 32'd3);
        do_step();
        chk("pat_wrap", pat(), 32'd0);

        // Correct guess on AND with a=b=1.
        do_step();
        do_step();
        do_step();
        chk("pat_for_and", pat(), 32'd3);
        gate_sel  = 3'd0;
        guess     = 1'b1;
        check_btn = 1'b1;
        cyc(7);
        chk("judge_c1_att", 32'(attempts), 32'd0);
        chk("judge_c1_ready", 32'(ready), 32'd0);
        cyc(1);
        chk("ok_att", 32'(attempts), 32'd1);
        chk("ok_cor", 32'(correct), 32'd1);
        chk("ok_flags", 32'({last_ok, last_bad}), 32'b10);
        chk("ok_ready", 32'(ready), 32'd1);
        cyc(2);
        check_btn = 1'b0;
        cyc(8);
        step_btn = 1'b1;
        cyc(6);
        chk("ok_held", 32'(last_ok), 32'd1);
        cyc(1);
        chk("ok_cleared", 32'(last_ok), 32'd0);
        cyc(3);
        step_btn = 1'b0;
        cyc(8);

        // Wrong guess on NOR with a=1, b=0.
        do_step();
        chk("pat_for_nor", pat(), 32'd1);
        gate_sel = 3'd4;
        guess    = 1'b1;
        do_check();
        chk("bad_att", 32'(attempts), 32'd2);
        chk("bad_cor", 32'(correct), 32'd1);
        chk("bad_flags", 32'({last_ok, last_bad}), 32'b01);

        // Simultaneous step and check: step wins, check dropped.
        step_btn  = 1'b1;
        check_btn = 1'b1;
        cyc(10);
        step_btn  = 1'b0;
        check_btn = 1'b0;
        cyc(8);
        chk("coll_pat", pat(), 32'd2);
        chk("coll_att", 32'(attempts), 32'd2);

        // Asynchronous reset while in SETTLE.
        step_btn = 1'b1;
        cyc(8);
        chk("mid_settle", 32'({pat(), ready}), 32'b110);
        rst_n = 1'b0;
        #1;
        chk("arst_pat", pat(), 32'd0);
        chk("arst_cnt", 32'({attempts, correct}), 32'd0);
        chk("arst_flags", 32'({last_ok, last_bad}), 32'd0);
        chk("arst_ready", 32'(ready), 32'd1);
        step_btn = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Saturation: OR with a=b=0 is 0.
        gate_sel = 3'd1;
        guess    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_check();
            chk("sat_att", 32'(attempts), (i < 15) ? 32'(i + 1) : 32'd15);
        end
        chk("sat_cor", 32'(correct), 32'd15);
        chk("sat_ok", 32'(last_ok), 32'd1);

`ifdef GATE_QUIZ_AUTO_EN
        p_exp   = pat()[1:0];
        auto_en = 1'b1;
        cyc(7);
        chk("auto_wait", pat(), 32'(p_exp));
        cyc(1);
        p_exp = p_exp + 2'd1;
        chk("auto_1", pat(), 32'(p_exp));
        cyc(8);
        p_exp = p_exp + 2'd1;
        chk("auto_2", pat(), 32'(p_exp));
        cyc(3);
        auto_en = 1'b0;
        cyc(20);
        chk("auto_off", pat(), 32'(p_exp));
        auto_en = 1'b1;
        cyc(7);
        chk("auto_clr_wait", pat(), 32'(p_exp));
        cyc(1);
        p_exp = p_exp + 2'd1;
        chk("auto_clr_step", pat(), 32'(p_exp));
        auto_en = 1'b0;
`else
        p_exp   = pat()[1:0];
        auto_en = 1'b1;
        cyc(24);
        chk("auto_ignored", pat(), 32'(p_exp));
        auto_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
